// File: rtl/template_pkg.sv
// template_pkg: shared constants, line/window sum structs and the window width helper.
// Defaults describe 8-bit pixels on 64-pixel lines; modules re-derive their own widths.
package template_pkg;
    localparam int PIXEL_SIZE = 8;
    localparam int LINE_SIZE = 64;
    localparam int NUM_TEMPLATES = 10;
    localparam int DEF_WINDOW_LINES = 8;
    // Sum of I^2 over one line needs twice the pixel width plus the line-length growth.
    localparam int LINE_W = 2 * PIXEL_SIZE + $clog2(LINE_SIZE);

    function automatic int win_w(input int line_w, input int lines);
        return line_w + $clog2(lines + 1);
    endfunction

    localparam int WIN_W = win_w(LINE_W, DEF_WINDOW_LINES);

    typedef struct packed {
        logic [LINE_W-1:0]                    sq;
        logic [LINE_W-1:0]                    s;
        logic [NUM_TEMPLATES-1:0][LINE_W-1:0] txi;
    } line_sums_t;

    typedef struct packed {
        logic [WIN_W-1:0]                    sq;
        logic [WIN_W-1:0]                    s;
        logic [NUM_TEMPLATES-1:0][WIN_W-1:0] txi;
    } win_sums_t;
endpackage

// File: rtl/window_history_buffer.sv
// window_history_buffer: circular store of the last DEPTH line-sum entries.
// Ports: clk/rst (async high), clr (drop history), wr_en/restart (write, restart
// makes this line entry 0), wr_data; oldest = entry about to be overwritten,
// full = history currently holds DEPTH lines, full_next = it will after this edge.
module window_history_buffer
    import template_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = line_sums_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   wr_en,
    input  logic   restart,
    input  entry_t wr_data,
    output entry_t oldest,
    output logic   full,
    output logic   full_next
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_addr;
    logic [CNT_W-1:0] fill_q, fill_d;
    entry_t           mem_q [DEPTH];

    always_comb begin
        wr_addr  = (wr_en && restart) ? '0 : wr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (clr) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end else if (wr_en) begin
            wr_ptr_d = (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
            fill_d   = restart ? CNT_W'(1) : (fill_q == FULL ? FULL : fill_q + 1'b1);
        end
    end

    assign full      = fill_q == FULL;
    assign full_next = fill_d == FULL;
    assign oldest    = mem_q[wr_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // History contents need no reset: the fill count masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end
endmodule

// File: rtl/template_window_accumulator.sv
// template_window_accumulator: vertical sliding-window sums of per-line I^2, I and T*I.
// Ports: CLK/RST (async high); frame_start/in_valid/in_ready with the line sums in;
// out_valid/out_ready with the window sums and out_row (top line of window) out.
module template_window_accumulator #(
    parameter int  NUM_TEMPLATES = 10,
    parameter int  LINE_SUM_W    = 22,
    parameter int  WINDOW_LINES  = 8,
    parameter int  ROW_W         = 12,
    localparam int WIN_SUM_W     = template_pkg::win_w(LINE_SUM_W, WINDOW_LINES)
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    frame_start,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [LINE_SUM_W-1:0]                   I_square_line_sum,
    input  logic [LINE_SUM_W-1:0]                   I_line_sum,
    input  logic [NUM_TEMPLATES-1:0][LINE_SUM_W-1:0] T_x_I_line_sums,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [WIN_SUM_W-1:0]                    I_square_win_sum,
    output logic [WIN_SUM_W-1:0]                    I_win_sum,
    output logic [NUM_TEMPLATES-1:0][WIN_SUM_W-1:0] T_x_I_win_sums,
    output logic [ROW_W-1:0]                        out_row
);
    typedef struct packed {
        logic [LINE_SUM_W-1:0]                    sq;
        logic [LINE_SUM_W-1:0]                    s;
        logic [NUM_TEMPLATES-1:0][LINE_SUM_W-1:0] txi;
    } line_t;

    typedef struct packed {
        logic [WIN_SUM_W-1:0]                    sq;
        logic [WIN_SUM_W-1:0]                    s;
        logic [NUM_TEMPLATES-1:0][WIN_SUM_W-1:0] txi;
    } win_t;

    // The oldest line is always contained in acc, so the result never underflows.
    function automatic logic [WIN_SUM_W-1:0] roll(input logic [WIN_SUM_W-1:0] acc,
                                                  input logic [LINE_SUM_W-1:0] add,
                                                  input logic [LINE_SUM_W-1:0] sub);
        return acc + WIN_SUM_W'(add) - WIN_SUM_W'(sub);
    endfunction

    line_t            new_line, oldest, old;
    win_t             base, sums_q, sums_d, out_q, out_d;
    logic             accept, restart, clr, load, full, full_next;
    logic             out_valid_q, out_valid_d;
    logic [ROW_W-1:0] row_q, row_d, out_row_q, out_row_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign restart  = accept && frame_start;
    assign clr      = frame_start && !in_valid;
    assign load     = accept && full_next;
    assign new_line = '{sq: I_square_line_sum, s: I_line_sum, txi: T_x_I_line_sums};

    window_history_buffer #(
        .DEPTH   (WINDOW_LINES),
        .entry_t (line_t)
    ) u_hist (
        .clk       (CLK),
        .rst       (RST),
        .clr       (clr),
        .wr_en     (accept),
        .restart   (restart),
        .wr_data   (new_line),
        .oldest    (oldest),
        .full      (full),
        .full_next (full_next)
    );

    always_comb begin
        // A restarting line behaves as if accumulated onto cleared state.
        base   = restart ? '0 : sums_q;
        old    = (full && !restart) ? oldest : '0;
        sums_d = sums_q;
        if (clr) begin
            sums_d = '0;
        end else if (accept) begin
            sums_d.sq = roll(base.sq, new_line.sq, old.sq);
            sums_d.s  = roll(base.s, new_line.s, old.s);
            for (int t = 0; t < NUM_TEMPLATES; t++)
                sums_d.txi[t] = roll(base.txi[t], new_line.txi[t], old.txi[t]);
        end
        row_d       = (clr || restart) ? '0 : row_q;
        out_row_d   = load ? row_d : out_row_q;
        row_d       = load ? row_d + 1'b1 : row_d;
        out_d       = load ? sums_d : out_q;
        out_valid_d = load || (!(clr || restart) && out_valid_q && !out_ready);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sums_q      <= '0;
            out_q       <= '0;
            row_q       <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sums_q      <= sums_d;
            out_q       <= out_d;
            row_q       <= row_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign I_square_win_sum = out_q.sq;
    assign I_win_sum        = out_q.s;
    assign T_x_I_win_sums   = out_q.txi;
    assign out_row          = out_row_q;
endmodule

// File: tb/tb_template_window_accumulator.sv
// tb_template_window_accumulator: directed vectors against three window depths.
module tb_template_window_accumulator;
    logic CLK = 1'b0, RST = 1'b1, frame_start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [21:0] sq_in = '0, s_in = '0;
    logic [1:0][21:0] txi_in = '0;
    int n_vec = 0, n_err = 0;

    logic rdy3, val3, rdy8, val8, rdy1, val1;
    logic [23:0] sq3, s3;
    logic [1:0][23:0] txi3;
    logic [25:0] sq8, s8;
    logic [1:0][25:0] txi8;
    logic [22:0] sq1, s1;
    logic [1:0][22:0] txi1;
    logic [11:0] row3, row8, row1;

    always #5 CLK = ~CLK;

    template_window_accumulator #(.NUM_TEMPLATES(2), .WINDOW_LINES(3)) u3 (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .in_valid(in_valid), .in_ready(rdy3),
        .I_square_line_sum(sq_in), .I_line_sum(s_in), .T_x_I_line_sums(txi_in),
        .out_valid(val3), .out_ready(out_ready), .I_square_win_sum(sq3), .I_win_sum(s3),
        .T_x_I_win_sums(txi3), .out_row(row3));

    template_window_accumulator #(.NUM_TEMPLATES(2), .WINDOW_LINES(8)) u8 (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .in_valid(in_valid), .in_ready(rdy8),
        .I_square_line_sum(sq_in), .I_line_sum(s_in), .T_x_I_line_sums(txi_in),
        .out_valid(val8), .out_ready(out_ready), .I_square_win_sum(sq8), .I_win_sum(s8),
        .T_x_I_win_sums(txi8), .out_row(row8));

    template_window_accumulator #(.NUM_TEMPLATES(2), .WINDOW_LINES(1)) u1 (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .in_valid(in_valid), .in_ready(rdy1),
        .I_square_line_sum(sq_in), .I_line_sum(s_in), .T_x_I_line_sums(txi_in),
        .out_valid(val1), .out_ready(out_ready), .I_square_win_sum(sq1), .I_win_sum(s1),
        .T_x_I_win_sums(txi1), .out_row(row1));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic [21:0] v);
        frame_start = fs;
        in_valid    = 1'b1;
        s_in        = v;
        sq_in       = 22'(v * v);
        txi_in[0]   = v;
        txi_in[1]   = 22'(v * 10);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        out_ready = 1'b1;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_valid", 64'(val3), 0);
        check("rst_sum", 64'(s3), 0);
        check("rst_row", 64'(row3), 0);
        check("rst_sum8", 64'(s8), 0);
        tick();
        RST = 1'b0;
        #1;
        check("rst_ready", 64'(rdy3), 1);

        // Basic stream 1..5 into the 3-line window
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 22'(i));
            tick();
            check("stream_ready", 64'(rdy3), 1);
            if (i >= 3) begin
                check("stream_valid", 64'(val3), 1);
                check("stream_sum", 64'(s3), 64'(3 * i - 3));
                check("stream_row", 64'(row3), 64'(i - 3));
            end else begin
                check("stream_fill_valid", 64'(val3), 0);
            end
            if (i == 3) begin
                check("stream_sq", 64'(sq3), 14);
                check("stream_txi0", 64'(txi3[0]), 6);
                check("stream_txi1", 64'(txi3[1]), 60);
            end
        end
        idle();
        tick();
        check("drain_valid", 64'(val3), 0);

        // Backpressure holds the first window and blocks input
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 22'(i));
            tick();
        end
        check("bp_first", 64'(s3), 6);
        out_ready = 1'b0;
        drive(1'b0, 22'd4);
        #1;
        check("bp_ready", 64'(rdy3), 0);
        tick();
        check("bp_hold_valid", 64'(val3), 1);
        check("bp_hold_sum", 64'(s3), 6);
        tick();
        check("bp_hold_sum2", 64'(s3), 6);
        check("bp_hold_row", 64'(row3), 0);
        out_ready = 1'b1;
        tick();
        check("bp_resume_sum", 64'(s3), 9);
        check("bp_resume_row", 64'(row3), 1);
        idle();
        tick();

        // Full-scale lines into the 8-line window: no wrap
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 22'h3FFFFF);
            sq_in     = 22'h3FFFFF;
            txi_in[1] = 22'h3FFFFF;
            tick();
            if (i == 7) check("max_fill_valid", 64'(val8), 0);
            if (i >= 8) begin
                check("max_sum", 64'(s8), 64'd33554424);
                check("max_row", 64'(row8), 64'(i - 8));
            end
            if (i == 20) begin
                check("max_sq", 64'(sq8), 64'd33554424);
                check("max_txi1", 64'(txi8[1]), 64'd33554424);
            end
        end
        idle();
        tick();

        // frame_start with a line discards the pending window and restarts rows
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 22'(i));
            tick();
        end
        check("fs_pending", 64'(val3), 1);
        drive(1'b1, 22'd4);
        tick();
        check("fs_discard", 64'(val3), 0);
        drive(1'b0, 22'd5);
        tick();
        check("fs_fill", 64'(val3), 0);
        drive(1'b0, 22'd6);
        tick();
        check("fs_sum", 64'(s3), 15);
        check("fs_row", 64'(row3), 0);
        // frame_start alone clears everything
        idle();
        frame_start = 1'b1;
        tick();
        check("fsclr_valid", 64'(val3), 0);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 22'd1);
            tick();
            if (i < 3) check("fsclr_fill", 64'(val3), 0);
        end
        check("fsclr_sum", 64'(s3), 3);
        check("fsclr_row", 64'(row3), 0);
        idle();
        tick();

        // Asynchronous reset mid-stream
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 22'(i));
            tick();
        end
        check("mid_before", 64'(s3), 9);
        idle();
        RST = 1'b1;
        #1;
        check("mid_rst_valid", 64'(val3), 0);
        check("mid_rst_sum", 64'(s3), 0);
        check("mid_rst_row", 64'(row3), 0);
        tick();
        RST = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 22'd7);
            tick();
            if (i < 3) check("mid_fill", 64'(val3), 0);
        end
        check("mid_sum", 64'(s3), 21);
        check("mid_row", 64'(row3), 0);
        idle();
        tick();

        // Single-line window is a registered passthrough with a row count
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 22'(i + 1));
            txi_in[0] = 22'd10;
            txi_in[1] = 22'd20;
            tick();
            check("w1_valid", 64'(val1), 1);
            check("w1_txi0", 64'(txi1[0]), 10);
            check("w1_txi1", 64'(txi1[1]), 20);
            check("w1_sum", 64'(s1), 64'(i + 1));
            check("w1_row", 64'(row1), 64'(i));
        end
        drive(1'b1, 22'd9);
        tick();
        check("w1_fs_valid", 64'(val1), 1);
        check("w1_fs_sum", 64'(s1), 9);
        check("w1_fs_row", 64'(row1), 0);
        idle();
        tick();
        check("w1_drain", 64'(val1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
